irq_request_unit: RTL and testbench

- Sits directly upstream of the interrupt controller and generates its active-low `interrupt_signal`.
- Synchronizes asynchronous external interrupt lines and edge-detects them into sticky pending bits.
- Applies a per-line mask and fixed priority, then holds one committed request until the controller enters and returns from the ISR.
- Uses the controller's `sel_ISR` and `ret_ISR` outputs as its acknowledge and completion handshake.

---
 rtl/irq_request_unit_if.sv | 27 ++
 rtl/irq_request_unit.sv | 111 +++++++++++
 tb/tb_irq_request_unit.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/irq_request_unit_if.sv
// Request/acknowledge bundle between the interrupt request unit (master)
// and the interrupt controller (slave).
interface irq_request_unit_if #(
    parameter int ID_W = 2
);
    logic            interrupt_signal;
    logic [ID_W-1:0] irq_id;
    logic            irq_active;
    logic            sel_ISR;
    logic            ret_ISR;

    modport master (
        output interrupt_signal,
        output irq_id,
        output irq_active,
        input  sel_ISR,
        input  ret_ISR
    );

    modport slave (
        input  interrupt_signal,
        input  irq_id,
        input  irq_active,
        output sel_ISR,
        output ret_ISR
    );
endinterface

// File: rtl/irq_request_unit.sv
// Synchronizes and edge-detects external interrupt lines into sticky pending
// bits, then commits one masked, lowest-index-first request to the controller.
module irq_request_unit #(
    parameter int NUM_IRQ     = 4,
    parameter int ID_W        = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [NUM_IRQ-1:0] irq_mask,
    output logic [NUM_IRQ-1:0] irq_pending,
    irq_request_unit_if.master ctrl
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_q, sync_d;
    logic [NUM_IRQ-1:0] hist_q;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] sync_last;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] clr_mask;
    logic [ID_W-1:0]    win_idx;
    logic [ID_W-1:0]    id_q, id_d;
    state_t             state_q, state_d;
    logic               take;
    logic               intr_n_q;
    logic               active_q;

    // Element 0 takes the raw line; each stage shifts toward the last one.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], irq_in};
    end

    assign sync_last = sync_q[SYNC_STAGES-1];
    assign rise      = sync_last & ~hist_q;
    assign eligible  = pending_q & irq_mask;

    always_comb begin
        win_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_idx = ID_W'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        take    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|eligible) begin
                    state_d = REQ;
                    id_d    = win_idx;
                end
            end
            REQ: begin
                if (ctrl.sel_ISR) begin
                    state_d = SERVICE;
                    take    = 1'b1;
                end
            end
            SERVICE: begin
                if (ctrl.ret_ISR) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A rise in the clearing cycle re-arms the bit, so it is ORed in last.
    always_comb begin
        clr_mask  = take ? (NUM_IRQ'(1) << id_q) : '0;
        pending_d = (pending_q & ~clr_mask) | rise;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync_q    <= '0;
            hist_q    <= '0;
            pending_q <= '0;
            id_q      <= '0;
            state_q   <= IDLE;
            intr_n_q  <= 1'b1;
            active_q  <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            hist_q    <= sync_last;
            pending_q <= pending_d;
            id_q      <= id_d;
            state_q   <= state_d;
            intr_n_q  <= (state_d != REQ);
            active_q  <= (state_d != IDLE);
        end
    end

    assign irq_pending           = pending_q;
    assign ctrl.interrupt_signal = intr_n_q;
    assign ctrl.irq_id           = id_q;
    assign ctrl.irq_active       = active_q;

endmodule

// File: tb/tb_irq_request_unit.sv
// Bench for irq_request_unit: directed scenarios plus random traffic, with a
// cycle-level reference model feeding a scoreboard queue.
module tb_irq_request_unit;

    localparam int NUM_IRQ     = 4;
    localparam int ID_W        = 2;
    localparam int SYNC_STAGES = 2;

    typedef struct packed {
        logic               intr;
        logic [ID_W-1:0]    id;
        logic               act;
        logic [NUM_IRQ-1:0] pend;
    } exp_t;

    logic               clk = 1'b0;
    logic               nrst = 1'b0;
    logic [NUM_IRQ-1:0] irq_in = '0;
    logic [NUM_IRQ-1:0] irq_mask = '0;
    logic [NUM_IRQ-1:0] irq_pending;

    int n_vec  = 0;
    int n_fail = 0;
    exp_t exp_q[$];

    irq_request_unit_if #(.ID_W(ID_W)) ctrl ();

    irq_request_unit #(
        .NUM_IRQ    (NUM_IRQ),
        .ID_W       (ID_W),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .irq_in     (irq_in),
        .irq_mask   (irq_mask),
        .irq_pending(irq_pending),
        .ctrl       (ctrl)
    );

    always #5 clk = ~clk;

    function automatic int lowest_set(input logic [NUM_IRQ-1:0] v);
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    // Reference model: a line's rise reaches the pending set SYNC_STAGES edges
    // after capture, so the window keeps SYNC_STAGES+1 captured samples and
    // looks at its two oldest entries.
    initial begin : model
        int mode;
        int cur_id;
        logic [NUM_IRQ-1:0] pend;
        logic [NUM_IRQ-1:0] caps[$];
        logic [NUM_IRQ-1:0] rise, elig, clr;
        exp_t e;
        mode = 0;
        cur_id = 0;
        pend = '0;
        for (int i = 0; i <= SYNC_STAGES; i++) caps.push_back('0);
        forever begin
            @(posedge clk);
            if (!nrst) begin
                mode = 0;
                cur_id = 0;
                pend = '0;
                caps.delete();
                for (int i = 0; i <= SYNC_STAGES; i++) caps.push_back('0);
            end else begin
                rise = caps[1] & ~caps[0];
                elig = pend & irq_mask;
                clr  = '0;
                if (mode == 0) begin
                    if (elig != 0) begin
                        cur_id = lowest_set(elig);
                        mode = 1;
                    end
                end else if (mode == 1) begin
                    if (ctrl.sel_ISR) begin
                        clr[cur_id] = 1'b1;
                        mode = 2;
                    end
                end else begin
                    if (ctrl.ret_ISR) mode = 0;
                end
                pend = (pend & ~clr) | rise;
                caps.push_back(irq_in);
                void'(caps.pop_front());
            end
            e.intr = (mode != 1);
            e.id   = ID_W'(cur_id);
            e.act  = (mode != 0);
            e.pend = pend;
            exp_q.push_back(e);
        end
    end

    initial begin : monitor
        exp_t e;
        exp_t got;
        forever begin
            @(posedge clk);
            #1;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_empty at %0t: got no expectation, required one", $time);
            end else begin
                e = exp_q.pop_front();
                got = {ctrl.interrupt_signal, ctrl.irq_id, ctrl.irq_active, irq_pending};
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL cycle_outputs at %0t: got intr=%b id=%0d act=%b pend=%b, required intr=%b id=%0d act=%b pend=%b",
                             $time, got.intr, got.id, got.act, got.pend, e.intr, e.id, e.act, e.pend);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic pulse_sel();
        @(negedge clk);
        ctrl.sel_ISR = 1'b1;
        @(negedge clk);
        ctrl.sel_ISR = 1'b0;
    endtask

    task automatic pulse_ret();
        @(negedge clk);
        ctrl.ret_ISR = 1'b1;
        @(negedge clk);
        ctrl.ret_ISR = 1'b0;
    endtask

    initial begin : driver
        int hold[NUM_IRQ];
        bit seen;
        ctrl.sel_ISR = 1'b0;
        ctrl.ret_ISR = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_intr", ctrl.interrupt_signal, 1);
        chk("reset_id", ctrl.irq_id, 0);
        chk("reset_active", ctrl.irq_active, 0);
        chk("reset_pending", irq_pending, 0);
        nrst = 1'b1;
        irq_mask = '1;

        // Single line: request three edges after capture.
        @(negedge clk);
        irq_in[2] = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("tp1_not_yet", ctrl.interrupt_signal, 1);
        @(posedge clk);
        #1;
        chk("tp1_intr", ctrl.interrupt_signal, 0);
        chk("tp1_id", ctrl.irq_id, 2);
        chk("tp1_pending", irq_pending, 4'b0100);
        chk("tp1_active", ctrl.irq_active, 1);
        pulse_sel();
        chk("tp1_svc_pending", irq_pending, 0);
        chk("tp1_svc_intr", ctrl.interrupt_signal, 1);
        irq_in[2] = 1'b0;
        repeat (3) @(negedge clk);
        irq_in[2] = 1'b1;
        repeat (4) @(negedge clk);
        chk("tp4_svc_pending", irq_pending, 4'b0100);
        chk("tp4_svc_no_req", ctrl.interrupt_signal, 1);
        ctrl.ret_ISR = 1'b1;
        @(posedge clk);
        #1;
        chk("tp4_gap_intr", ctrl.interrupt_signal, 1);
        chk("tp4_gap_active", ctrl.irq_active, 0);
        @(negedge clk);
        ctrl.ret_ISR = 1'b0;
        @(posedge clk);
        #1;
        chk("tp4_rereq_intr", ctrl.interrupt_signal, 0);
        chk("tp4_rereq_id", ctrl.irq_id, 2);
        pulse_sel();
        pulse_ret();
        irq_in = '0;

        // Simultaneous rises: lowest index first, then the other.
        @(negedge clk);
        irq_in = 4'b1010;
        repeat (4) @(posedge clk);
        #1;
        chk("tp2_intr", ctrl.interrupt_signal, 0);
        chk("tp2_id", ctrl.irq_id, 1);
        pulse_sel();
        pulse_ret();
        @(posedge clk);
        #1;
        chk("tp2_next_intr", ctrl.interrupt_signal, 0);
        chk("tp2_next_id", ctrl.irq_id, 3);
        chk("tp2_next_pending", irq_pending, 4'b1000);
        pulse_sel();
        pulse_ret();
        irq_in = '0;

        // Masked line pends silently until enabled.
        @(negedge clk);
        irq_mask = 4'b1110;
        irq_in = 4'b0001;
        repeat (5) @(posedge clk);
        #1;
        chk("tp3_pending", irq_pending, 4'b0001);
        chk("tp3_masked", ctrl.interrupt_signal, 1);
        @(negedge clk);
        irq_mask = '1;
        @(posedge clk);
        #1;
        chk("tp3_intr", ctrl.interrupt_signal, 0);
        chk("tp3_id", ctrl.irq_id, 0);
        pulse_sel();
        pulse_ret();
        irq_in = '0;

        // ret_ISR in IDLE and in REQ is ignored.
        @(negedge clk);
        ctrl.ret_ISR = 1'b1;
        @(posedge clk);
        #1;
        chk("tp6_idle_intr", ctrl.interrupt_signal, 1);
        chk("tp6_idle_active", ctrl.irq_active, 0);
        @(negedge clk);
        ctrl.ret_ISR = 1'b0;
        irq_in = 4'b0010;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (ctrl.interrupt_signal == 1'b0) seen = 1'b1;
        end
        chk("tp6_req_seen", seen, 1);
        pulse_ret();
        chk("tp6_req_intr", ctrl.interrupt_signal, 0);
        chk("tp6_req_active", ctrl.irq_active, 1);

        // Async reset while in REQ, line held high through it.
        #2 nrst = 1'b0;
        #1;
        chk("tp5_rst_intr", ctrl.interrupt_signal, 1);
        chk("tp5_rst_pending", irq_pending, 0);
        chk("tp5_rst_active", ctrl.irq_active, 0);
        chk("tp5_rst_id", ctrl.irq_id, 0);
        @(negedge clk);
        nrst = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("tp5_rel_not_yet", ctrl.interrupt_signal, 1);
        @(posedge clk);
        #1;
        chk("tp5_rel_intr", ctrl.interrupt_signal, 0);
        chk("tp5_rel_id", ctrl.irq_id, 1);
        pulse_sel();
        pulse_ret();
        irq_in = '0;

        // Random traffic, lines held at least two cycles per level.
        for (int b = 0; b < NUM_IRQ; b++) hold[b] = 2;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int b = 0; b < NUM_IRQ; b++) begin
                if (hold[b] >= 2 && $urandom_range(0, 9) == 0) begin
                    irq_in[b] = ~irq_in[b];
                    hold[b] = 0;
                end else begin
                    hold[b]++;
                end
            end
            if ($urandom_range(0, 19) == 0) irq_mask = NUM_IRQ'($urandom);
            ctrl.sel_ISR = ($urandom_range(0, 3) == 0);
            ctrl.ret_ISR = ($urandom_range(0, 4) == 0);
            nrst = ($urandom_range(0, 299) != 0);
        end
        @(negedge clk);
        nrst = 1'b1;
        ctrl.sel_ISR = 1'b0;
        ctrl.ret_ISR = 1'b0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
